// File: rtl/qspi_mem_model_pkg.sv
// Shared types and constants for the QSPI memory model.
package qspi_mem_model_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } state_e;

  localparam logic [7:0] CMD_READ     = 8'h0B;
  localparam logic [7:0] CMD_WRITE    = 8'h02;
  localparam int         ADDR_NIBBLES = 6;

endpackage

// File: rtl/qspi_mem_bank.sv
// Single-port byte RAM for one chip select; bus writes are dropped on read-only banks.
module qspi_mem_bank
  import qspi_mem_model_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter bit READ_ONLY = 1'b0
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic                 bus_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [7:0]           wdata_i,
  output logic [7:0]           rdata_o
);

  logic [7:0] mem_q [2**ADDR_BITS];
  logic       write_ok;

  // Backdoor preloads must still reach read-only banks, so only bus writes are gated.
  assign write_ok = we_i && !(READ_ONLY && bus_i);

  always_ff @(posedge clk) begin
    if (write_ok) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/qspi_mem_model.sv
// Multi-bank QSPI memory responder that oversamples qspi_clk on the system clock.
// Optional QSPI_CONT_READ_EN: bank 0 skips the command phase and always reads.
module qspi_mem_model
  import qspi_mem_model_pkg::*;
#(
  parameter int                NUM_CS    = 3,
  parameter int                ADDR_BITS = 12,
  parameter logic [NUM_CS-1:0] RO_MASK   = 3'b001,
  localparam int               BANK_BITS = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 qspi_clk,
  input  logic [NUM_CS-1:0]    qspi_cs_n,
  input  logic [3:0]           qspi_dq_in,
  output logic [3:0]           qspi_dq_out,
  output logic                 qspi_dq_oe,
  input  logic [3:0]           dummy_cycles,
  input  logic                 load_en,
  input  logic [BANK_BITS-1:0] load_bank,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data,
  output logic                 protocol_err,
  output logic                 busy
);

  state_e               state_q;
  logic [BANK_BITS-1:0] bank_q;
  logic [3:0]           dummy_q;
  logic [2:0]           cnt_q;
  logic [3:0]           cmd_hi_q;
  logic [3:0]           whi_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 is_read_q;
  logic                 nib_lo_q;
  logic                 clk_prev_q;
  logic [3:0]           dq_out_q;
  logic                 dq_oe_q;
  logic                 err_q;
  logic                 busy_q;

  logic                 clk_rise;
  logic                 clk_fall;
  int                   low_count;
  logic [BANK_BITS-1:0] first_low;
  logic                 multi_low;
  logic                 any_low;
  logic                 bank_cs_high;
  logic                 bus_commit;
  logic                 load_fire;
  logic [7:0]           cmd_d;
  logic [7:0]           wbyte_d;
  logic [ADDR_BITS-1:0] addr_shift_d;
  logic [7:0]           bank_rdata [NUM_CS];
  logic [7:0]           cur_rdata;

  assign clk_rise     = qspi_clk && !clk_prev_q;
  assign clk_fall     = !qspi_clk && clk_prev_q;
  assign multi_low    = (low_count > 1);
  assign any_low      = (low_count != 0);
  assign bank_cs_high = qspi_cs_n[bank_q];
  assign cmd_d        = {cmd_hi_q, qspi_dq_in};
  assign wbyte_d      = {whi_q, qspi_dq_in};
  // Only the low ADDR_BITS of the 24-bit address survive the shift.
  assign addr_shift_d = {addr_q[ADDR_BITS-5:0], qspi_dq_in};
  assign cur_rdata    = bank_rdata[bank_q];
  assign load_fire    = load_en && (&qspi_cs_n);
  assign bus_commit   = (state_q == ST_WDATA) && clk_rise && nib_lo_q && !bank_cs_high && !multi_low;

  always_comb begin
    low_count = 0;
    first_low = '0;
    for (int i = NUM_CS - 1; i >= 0; i--) begin
      if (!qspi_cs_n[i]) begin
        low_count = low_count + 1;
        first_low = BANK_BITS'(i);
      end
    end
  end

  for (genvar g = 0; g < NUM_CS; g++) begin : g_bank
    logic                 bus_we;
    logic                 bank_we;
    logic [ADDR_BITS-1:0] bank_addr;
    logic [7:0]           bank_wdata;

    assign bus_we     = bus_commit && (bank_q == BANK_BITS'(g));
    assign bank_we    = bus_we || (load_fire && (load_bank == BANK_BITS'(g)));
    assign bank_addr  = (load_fire && !bus_we) ? load_addr : addr_q;
    assign bank_wdata = bus_we ? wbyte_d : load_data;

    qspi_mem_bank #(
      .ADDR_BITS(ADDR_BITS),
      .READ_ONLY(RO_MASK[g])
    ) u_bank (
      .clk    (clk),
      .we_i   (bank_we),
      .bus_i  (bus_we),
      .addr_i (bank_addr),
      .wdata_i(bank_wdata),
      .rdata_o(bank_rdata[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bank_q     <= '0;
      dummy_q    <= '0;
      cnt_q      <= '0;
      cmd_hi_q   <= '0;
      whi_q      <= '0;
      addr_q     <= '0;
      is_read_q  <= 1'b0;
      nib_lo_q   <= 1'b0;
      clk_prev_q <= 1'b0;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      clk_prev_q <= qspi_clk;
      if (load_en && bus_commit) begin
        err_q <= 1'b1;
      end

      if (multi_low) begin
        state_q <= ST_IGNORE;
        err_q   <= 1'b1;
        dq_oe_q <= 1'b0;
        busy_q  <= 1'b1;
      end else if (state_q == ST_IDLE) begin
        if (any_low) begin
          bank_q   <= first_low;
          dummy_q  <= dummy_cycles;
          cnt_q    <= '0;
          nib_lo_q <= 1'b0;
          busy_q   <= 1'b1;
`ifdef QSPI_CONT_READ_EN
          if (first_low == '0) begin
            state_q   <= ST_ADDR;
            is_read_q <= 1'b1;
          end else begin
            state_q <= ST_CMD;
          end
`else
          state_q <= ST_CMD;
`endif
        end
      end else if (state_q == ST_IGNORE) begin
        if (&qspi_cs_n) begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      end else if (bank_cs_high) begin
        state_q <= ST_IDLE;
        dq_oe_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_CMD: if (clk_rise) begin
            cmd_hi_q <= qspi_dq_in;
            if (cnt_q == 3'd1) begin
              cnt_q <= '0;
              if (cmd_d == CMD_READ) begin
                is_read_q <= 1'b1;
                state_q   <= ST_ADDR;
              end else if (cmd_d == CMD_WRITE) begin
                is_read_q <= 1'b0;
                state_q   <= ST_ADDR;
              end else begin
                err_q   <= 1'b1;
                state_q <= ST_IGNORE;
              end
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
          ST_ADDR: if (clk_rise) begin
            addr_q <= addr_shift_d;
            if (cnt_q == 3'(ADDR_NIBBLES - 1)) begin
              cnt_q    <= '0;
              nib_lo_q <= 1'b0;
              if (!is_read_q) begin
                state_q <= ST_WDATA;
              end else if (dummy_q == 4'd0) begin
                state_q <= ST_RDATA;
              end else begin
                state_q <= ST_DUMMY;
              end
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
          ST_DUMMY: if (clk_rise) begin
            dummy_q <= dummy_q - 4'd1;
            if (dummy_q == 4'd1) begin
              state_q <= ST_RDATA;
            end
          end
          ST_RDATA: if (clk_fall) begin
            dq_oe_q <= 1'b1;
            if (!nib_lo_q) begin
              dq_out_q <= cur_rdata[7:4];
              nib_lo_q <= 1'b1;
            end else begin
              dq_out_q <= cur_rdata[3:0];
              nib_lo_q <= 1'b0;
              addr_q   <= addr_q + 1'b1;
            end
          end
          ST_WDATA: if (clk_rise) begin
            if (!nib_lo_q) begin
              whi_q    <= qspi_dq_in;
              nib_lo_q <= 1'b1;
            end else begin
              nib_lo_q <= 1'b0;
              addr_q   <= addr_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign qspi_dq_out  = dq_out_q;
  assign qspi_dq_oe   = dq_oe_q;
  assign protocol_err = err_q;
  assign busy         = busy_q;

endmodule
